// File: rtl/prog_loader_if.sv
// Loader-side bundle: byte stream in (valid/ready), combinational fetch port, core control and status.
// The master modport is the stream/fetch producer; the slave modport is prog_loader.
interface prog_loader_if;
    logic [7:0]  inByte;
    logic        inValid;
    logic        inReady;
    logic [15:0] progAddr;
    logic [15:0] progInstr;
    logic        cpuReset;
    logic        loadDone;
    logic        loadError;
    logic [15:0] wordCount;

    modport master (
        output inByte, inValid, progAddr,
        input  inReady, progInstr, cpuReset, loadDone, loadError, wordCount
    );

    modport slave (
        input  inByte, inValid, progAddr,
        output inReady, progInstr, cpuReset, loadDone, loadError, wordCount
    );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: header N then N little-endian words into RAM, core held in reset until done; fetch is 0-latency.
// One byte per cycle when inValid && inReady; inReady drops permanently in RUN/ERROR until reset.
module prog_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [15:0] NOP_INSTR   = 16'h01C0
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [2:0] {
        HDR_LO, HDR_HI, DATA_LO, DATA_HI, RUN, ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic [15:0]   word_count_q, word_count_d;
    logic [AW-1:0] wp_q, wp_d;

    logic [15:0]   mem [DEPTH_WORDS];
    logic          mem_we;
    logic [15:0]   n_full;
    logic          in_ready;
    logic          xfer;
    logic [14:0]   idx;
    logic          hit;
    logic          unused_addr_lsb;

    assign in_ready = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                      (state_q == DATA_LO) || (state_q == DATA_HI);
    assign xfer     = bus.inValid && in_ready;
    assign n_full   = {bus.inByte, hold_q};

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        word_count_d = word_count_q;
        wp_d         = wp_q;
        mem_we       = 1'b0;
        case (state_q)
            HDR_LO: begin
                if (xfer) begin
                    hold_d  = bus.inByte;
                    state_d = HDR_HI;
                end
            end
            HDR_HI: begin
                if (xfer) begin
                    word_count_d = n_full;
                    wp_d         = '0;
                    if ({1'b0, n_full} > 17'(DEPTH_WORDS)) begin
                        state_d = ERROR;
                    end else if (n_full == 16'd0) begin
                        state_d = RUN;
                    end else begin
                        state_d = DATA_LO;
                    end
                end
            end
            DATA_LO: begin
                if (xfer) begin
                    hold_d  = bus.inByte;
                    state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (xfer) begin
                    mem_we = 1'b1;
                    // N >= 1 here, so N-1 cannot underflow
                    if (16'(wp_q) == word_count_q - 16'd1) begin
                        state_d = RUN;
                    end else begin
                        wp_d    = wp_q + AW'(1);
                        state_d = DATA_LO;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HDR_LO;
            hold_q       <= '0;
            word_count_q <= '0;
            wp_q         <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            word_count_q <= word_count_d;
            wp_q         <= wp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[wp_q] <= {bus.inByte, hold_q};
        end
    end

    // wordCount <= DEPTH_WORDS, so the bound check also keeps idx inside the RAM
    assign idx             = bus.progAddr[15:1];
    assign unused_addr_lsb = bus.progAddr[0];
    assign hit             = (state_q == RUN) && (16'(idx) < word_count_q);
    assign bus.progInstr   = hit ? mem[idx[AW-1:0]] : NOP_INSTR;

    assign bus.inReady   = in_ready;
    assign bus.cpuReset  = (state_q != RUN);
    assign bus.loadDone  = (state_q == RUN);
    assign bus.loadError = (state_q == ERROR);
    assign bus.wordCount = word_count_q;
endmodule
